// File: rtl/uart_tx_buffered_if.sv
// Byte-write handshake between the upstream send-data stage and the buffered UART transmitter.
interface uart_tx_buffered_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       data_in_ready;

  modport master (output tx_data, output tx_valid, input data_in_ready);
  modport slave  (input tx_data, input tx_valid, output data_in_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames are sent back-to-back while bytes are queued.
module uart_tx_buffered #(
  parameter int CLK_DIV = 10417,
  parameter int DEPTH   = 4
) (
  input  logic                   uart_clk,
  input  logic                   rst_n,
  uart_tx_buffered_if.slave      up,
  output logic                   uart_txd,
  output logic                   busy,
  output logic                   overflow,
  output logic [7:0]             tx_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0]    ST_IDLE   = 2'd0;
  localparam logic [1:0]    ST_START  = 2'd1;
  localparam logic [1:0]    ST_DATA   = 2'd2;
  localparam logic [1:0]    ST_STOP   = 2'd3;
  localparam logic [15:0]   BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [1:0]    state_q,    state_d;
  logic [15:0]   baud_q,     baud_d;
  logic [2:0]    bit_idx_q,  bit_idx_d;
  logic [7:0]    shift_q,    shift_d;
  logic          txd_q,      txd_d;
  logic [7:0]    tx_count_q, tx_count_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic fifo_ready;
  logic fifo_empty;
  logic baud_last;
  logic wr_en;
  logic pop;

  assign fifo_ready = (count_q != CNT_FULL);
  assign fifo_empty = (count_q == {CW{1'b0}});
  assign baud_last  = (baud_q == BAUD_LAST);
  assign wr_en      = up.tx_valid & fifo_ready;

  // Frame sequencer: the line level for the next bit is decided here so uart_txd only moves on bit boundaries.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    tx_count_d = tx_count_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = 16'd0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
          state_d = ST_START;
        end else begin
          txd_d = 1'b1;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d    = 16'd0;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d     = 16'd0;
          tx_count_d = tx_count_q + 8'd1;
          // Chain straight into the next start bit when another byte is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
            state_d = ST_START;
          end else begin
            txd_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        baud_d  = 16'd0;
        txd_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Byte FIFO bookkeeping; a write is judged against the pre-edge count even when a pop happens alongside.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (up.tx_valid & ~fifo_ready);
    if (wr_en) begin
      mem_d[wr_ptr_q] = up.tx_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_q     <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      txd_q      <= 1'b1;
      tx_count_q <= 8'd0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      tx_count_q <= tx_count_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign up.data_in_ready = fifo_ready;
  assign uart_txd         = txd_q;
  assign busy             = (state_q != ST_IDLE) | ~fifo_empty;
  assign overflow         = overflow_q;
  assign tx_count         = tx_count_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: vector table for one frame, a serial-line monitor with byte scoreboard, and corner-case sequences.
module tb_uart_tx_buffered;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;

  typedef struct {
    int         cyc;
    logic       v;
    logic [7:0] d;
    logic       txd;
    logic       bsy;
    logic       rdy;
    logic [7:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_txd;
  logic       busy;
  logic       overflow;
  logic [7:0] tx_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];
  logic       mon_off;
  logic       m_active;
  int         m_cnt;
  logic [7:0] m_byte;
  int         exp_txc;

  uart_tx_buffered_if up_if ();

  uart_tx_buffered #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .uart_clk (clk),
    .rst_n    (rst_n),
    .up       (up_if.slave),
    .uart_txd (uart_txd),
    .busy     (busy),
    .overflow (overflow),
    .tx_count (tx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial receiver: samples each bit mid-period and compares the byte with the scoreboard head.
  initial begin
    m_active = 1'b0;
    m_cnt    = 0;
    m_byte   = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n || mon_off) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (uart_txd == 1'b0) begin
          m_active = 1'b1;
          m_cnt    = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == 2) chk("rx_start_bit", 32'(uart_txd), 32'd0);
        if (m_cnt >= 6 && m_cnt <= 34 && ((m_cnt - 6) % 4) == 0)
          m_byte[3'((m_cnt - 6) / 4)] = uart_txd;
        if (m_cnt == 38) begin
          chk("rx_stop_bit", 32'(uart_txd), 32'd1);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected_frame: got 0x%0h, expected no frame", m_byte);
          end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (m_byte !== e) begin
              errors++;
              $display("FAIL rx_byte: got 0x%0h, expected 0x%0h", m_byte, e);
            end
          end
        end
        if (m_cnt == 39) m_active = 1'b0;
      end
    end
  end

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < max_cyc);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
    end
    @(negedge clk);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({name, "_tx_count"}, 32'(tx_count), 32'(exp_txc));
  endtask

  task automatic burst5(input logic [7:0] base);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        @(negedge clk);
        chk("burst_ready", 32'(up_if.data_in_ready), 32'd1);
      end
      up_if.tx_valid = 1'b1;
      up_if.tx_data  = base + 8'(j);
      sb.push_back(base + 8'(j));
    end
    @(negedge clk);
    chk("burst_full_ready", 32'(up_if.data_in_ready), 32'd0);
    chk("burst_overflow", 32'(overflow), 32'd0);
    up_if.tx_valid = 1'b0;
  endtask

  task automatic stream(input int first, input int n);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < n && guard < n * 60 + 100) begin
      @(negedge clk);
      guard++;
      if (up_if.data_in_ready) begin
        up_if.tx_valid = 1'b1;
        up_if.tx_data  = 8'((first + sent) * 37 + 11);
        sb.push_back(8'((first + sent) * 37 + 11));
        sent++;
      end else begin
        up_if.tx_valid = 1'b0;
      end
    end
    @(negedge clk);
    up_if.tx_valid = 1'b0;
    chk("stream_sent", 32'(sent), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [$];
    int   cur;
    logic quiet;

    rst_n          = 1'b0;
    mon_off        = 1'b0;
    up_if.tx_valid = 1'b0;
    up_if.tx_data  = 8'd0;
    exp_txc        = 0;

    // 0xA5 sent LSB first: 1,0,1,0,0,1,0,1; offsets count negedges from the write drive.
    tbl.push_back('{0,  1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'd0});
    tbl.push_back('{1,  1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{2,  1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{5,  1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{6,  1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{9,  1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{13, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{14, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{18, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{22, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{26, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{30, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{34, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{37, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{38, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{41, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'd0});
    tbl.push_back('{42, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd1});

    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(uart_txd), 32'd1);
    chk("reset_ready", 32'(up_if.data_in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_tx_count", 32'(tx_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, cycle-exact.
    cur = 0;
    foreach (tbl[i]) begin
      while (cur < tbl[i].cyc) begin
        @(negedge clk);
        cur++;
      end
      chk($sformatf("vec%0d_txd", tbl[i].cyc), 32'(uart_txd), 32'(tbl[i].txd));
      chk($sformatf("vec%0d_busy", tbl[i].cyc), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("vec%0d_ready", tbl[i].cyc), 32'(up_if.data_in_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_tx_count", tbl[i].cyc), 32'(tx_count), 32'(tbl[i].cnt));
      up_if.tx_valid = tbl[i].v;
      up_if.tx_data  = tbl[i].d;
      if (tbl[i].v) sb.push_back(tbl[i].d);
    end
    exp_txc = 1;
    @(negedge clk);

    // Five-byte burst: frames back-to-back, busy for 200 cycles after the first pop.
    burst5(8'h01);
    repeat (196) @(negedge clk);
    chk("burst_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    chk("burst_busy_done", 32'(busy), 32'd0);
    exp_txc = 6;
    chk("burst_tx_count", 32'(tx_count), 32'(exp_txc));
    chk("burst_sb_empty", 32'(sb.size()), 32'd0);
    chk("burst_no_overflow", 32'(overflow), 32'd0);
    @(negedge clk);

    // Write on the STOP->START pop edge of a full FIFO is rejected.
    burst5(8'h21);
    repeat (36) @(negedge clk);
    chk("popedge_ready_before", 32'(up_if.data_in_ready), 32'd0);
    chk("popedge_overflow_before", 32'(overflow), 32'd0);
    up_if.tx_valid = 1'b1;
    up_if.tx_data  = 8'h99;
    @(negedge clk);
    up_if.tx_valid = 1'b0;
    chk("popedge_overflow", 32'(overflow), 32'd1);
    chk("popedge_ready_after", 32'(up_if.data_in_ready), 32'd1);
    exp_txc = 11;
    wait_idle("popedge", 300);
    chk("popedge_overflow_sticky", 32'(overflow), 32'd1);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    mon_off = 1'b1;
    up_if.tx_valid = 1'b1;
    up_if.tx_data  = 8'h3C;
    @(negedge clk);
    up_if.tx_data  = 8'h41;
    @(negedge clk);
    up_if.tx_data  = 8'h42;
    @(negedge clk);
    up_if.tx_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("rstmid_bit1_low", 32'(uart_txd), 32'd0);
    repeat (8) @(negedge clk);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_txd", 32'(uart_txd), 32'd1);
    chk("rstmid_ready", 32'(up_if.data_in_ready), 32'd1);
    chk("rstmid_tx_count", 32'(tx_count), 32'd0);
    chk("rstmid_overflow", 32'(overflow), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    mon_off = 1'b0;
    exp_txc = 0;
    sb.delete();
    quiet = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) quiet = 1'b0;
    end
    chk("rstmid_line_quiet", 32'(quiet), 32'd1);
    chk("rstmid_busy_after", 32'(busy), 32'd0);
    chk("rstmid_tx_count_after", 32'(tx_count), 32'd0);

    // 256 frames: tx_count wraps, FIFO pointers wrap many times.
    stream(0, 255);
    exp_txc = 255;
    wait_idle("stream255", 255 * 45 + 200);
    stream(255, 1);
    exp_txc = 0;
    wait_idle("stream256", 200);
    chk("stream_overflow", 32'(overflow), 32'd0);

    // Six writes into a full FIFO mid-frame are dropped.
    burst5(8'h10);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      up_if.tx_valid = 1'b1;
      up_if.tx_data  = 8'hE0 + 8'(k);
    end
    @(negedge clk);
    up_if.tx_valid = 1'b0;
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_ready", 32'(up_if.data_in_ready), 32'd0);
    exp_txc = 5;
    wait_idle("drop", 400);
    chk("drop_overflow_sticky", 32'(overflow), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
